hpdcache_victim_sel_ctrl: RTL and testbench

- Sequences and shares the cache victim-selection resource among NREQ miss-path requesters: the victim selector, its replacement-policy update port, and the directory read.
- Per granted request, the block reads the directory state of the target set, fires one victim selection, and updates the replacement policy with the chosen way.
- Results are returned through a 2-entry response FIFO.
- Sits between the miss handler/refill/prefetch requesters and the victim selector plus directory.

---
 rtl/hpdcache_victim_sel_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_hpdcache_victim_sel_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_victim_sel_ctrl.sv
// -----------------------------------------------------------------------------
// hpdcache_victim_sel_ctrl
//
// Shares the cache victim-selection resource among NREQ miss-path requesters.
// The resource is the victim selector, its replacement-policy update port and
// the directory read port.
//
// For each granted request the block does three things:
//   S0: arbitrates round-robin and issues the directory read for the set.
//   S1: one cycle later, fires exactly one victim selection using the
//       directory state returned this cycle. In the same cycle it updates the
//       replacement policy with the chosen way and pushes {id, set, way} into
//       a 2-entry response FIFO.
//
// External hit-driven policy updates share the update port. They only get
// through in cycles where S1 is empty.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_valid_i/req_set_i    per-requester request (set slice i for requester i)
//   req_ready_o              one-hot grant
//   dir_rd_o/dir_set_o       directory read strobe and set
//   dir_*_i                  directory state, valid one cycle after dir_rd_o
//   sel_victim_o/_set_o      victim selection strobe and set
//   sel_dir_*_o              directory state forwarded to the selector
//   sel_victim_way_i         one-hot victim returned combinationally
//   updt_o/_set_o/_way_o     replacement-policy update
//   hit_updt_*               external hit update request / acceptance
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_id_o/_set_o/_way_o   owning requester, set and one-hot victim way
// -----------------------------------------------------------------------------
module hpdcache_victim_sel_ctrl #(
    parameter int NREQ = 2,
    parameter int SETS = 64,
    parameter int WAYS = 4,
    localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1,
    localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,

    input  logic [NREQ-1:0]        req_valid_i,
    input  logic [NREQ*SET_W-1:0]  req_set_i,
    output logic [NREQ-1:0]        req_ready_o,

    output logic                   dir_rd_o,
    output logic [SET_W-1:0]       dir_set_o,
    input  logic [WAYS-1:0]        dir_valid_i,
    input  logic [WAYS-1:0]        dir_wback_i,
    input  logic [WAYS-1:0]        dir_dirty_i,
    input  logic [WAYS-1:0]        dir_fetch_i,

    output logic                   sel_victim_o,
    output logic [SET_W-1:0]       sel_victim_set_o,
    output logic [WAYS-1:0]        sel_dir_valid_o,
    output logic [WAYS-1:0]        sel_dir_wback_o,
    output logic [WAYS-1:0]        sel_dir_dirty_o,
    output logic [WAYS-1:0]        sel_dir_fetch_o,
    input  logic [WAYS-1:0]        sel_victim_way_i,

    output logic                   updt_o,
    output logic [SET_W-1:0]       updt_set_o,
    output logic [WAYS-1:0]        updt_way_o,

    input  logic                   hit_updt_valid_i,
    input  logic [SET_W-1:0]       hit_updt_set_i,
    input  logic [WAYS-1:0]        hit_updt_way_i,
    output logic                   hit_updt_ready_o,

    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic [SET_W-1:0]       rsp_set_o,
    output logic [WAYS-1:0]        rsp_way_o
);

    // Round-robin pointer and S0 arbitration signals
    logic [ID_W-1:0]  rr_ptr_q;
    logic [ID_W-1:0]  rr_ptr_nxt;
    logic [NREQ-1:0]  upper_mask;
    logic [NREQ-1:0]  upper_req;
    logic             gnt_found_p0;
    logic [ID_W-1:0]  gnt_idx_p0;
    logic             slot_free_p0;
    logic             vld_p0;
    logic [NREQ-1:0]  gnt_p0;
    logic [SET_W-1:0] set_p0;

    // S1 (select) stage
    logic             vld_p1;
    logic [ID_W-1:0]  id_p1;
    logic [SET_W-1:0] set_p1;

    // Hit-update arbitration
    logic             hit_acc;

    // Response FIFO
    logic [ID_W-1:0]  fifo_id_q  [2];
    logic [SET_W-1:0] fifo_set_q [2];
    logic [WAYS-1:0]  fifo_way_q [2];
    logic             fifo_wr_q;
    logic             fifo_rd_q;
    logic [1:0]       fifo_cnt_q;
    logic             fifo_push;
    logic             fifo_pop;

    // ---------------------------------------------------------------- S0 grant
    // A grant reserves a FIFO slot up front. The directory answer is consumed
    // in the next cycle and cannot be held, so a slot must already be
    // guaranteed when the read is issued. A pop in this cycle frees its slot
    // only from the next cycle on. Grants are also suppressed during reset,
    // so no output is high while rst_ni is low.
    assign slot_free_p0 = rst_ni && ((2'(vld_p1) + fifo_cnt_q) < 2'd2);

    // Round-robin arbiter. First look for requesters at or above the
    // pointer; if there are none, wrap around and take the lowest one.
    always_comb begin
        upper_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            upper_mask[i] = (ID_W'(i) >= rr_ptr_q);
        end
        upper_req    = req_valid_i & upper_mask;
        gnt_found_p0 = |req_valid_i;
        gnt_idx_p0   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if ((|upper_req) ? upper_req[i] : req_valid_i[i]) begin
                gnt_idx_p0 = ID_W'(i);
            end
        end
    end

    assign vld_p0 = slot_free_p0 && gnt_found_p0;

    always_comb begin
        gnt_p0 = '0;
        set_p0 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (vld_p0 && (gnt_idx_p0 == ID_W'(i))) begin
                gnt_p0[i] = 1'b1;
                set_p0    = req_set_i[i*SET_W +: SET_W];
            end
        end
    end

    assign rr_ptr_nxt = (gnt_idx_p0 == ID_W'(NREQ - 1)) ? '0 : gnt_idx_p0 + ID_W'(1);

    assign req_ready_o = gnt_p0;
    assign dir_rd_o    = vld_p0;
    assign dir_set_o   = set_p0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (vld_p0) begin
            rr_ptr_q <= rr_ptr_nxt;
        end
    end

    // ------------------------------------------------------ S0 -> S1 register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (vld_p0) begin
            id_p1  <= gnt_idx_p0;
            set_p1 <= set_p0;
        end
    end

    // --------------------------------------------------------------- S1 select
    // vld_p1 is a single-cycle token, so the selection strobe fires exactly
    // once per grant. The random policy advances on every strobe, which is why
    // the strobe must never repeat.
    assign sel_victim_o     = vld_p1;
    assign sel_victim_set_o = vld_p1 ? set_p1      : '0;
    assign sel_dir_valid_o  = vld_p1 ? dir_valid_i : '0;
    assign sel_dir_wback_o  = vld_p1 ? dir_wback_i : '0;
    assign sel_dir_dirty_o  = vld_p1 ? dir_dirty_i : '0;
    assign sel_dir_fetch_o  = vld_p1 ? dir_fetch_i : '0;

    // The victim update owns the policy port whenever S1 is busy. Hit updates
    // wait. There is no bypass: the update is committed at this edge, so a
    // following request to the same set sees it in its own selection.
    assign hit_updt_ready_o = rst_ni && !vld_p1;
    assign hit_acc          = hit_updt_valid_i && hit_updt_ready_o;

    assign updt_o     = vld_p1 || hit_acc;
    assign updt_set_o = vld_p1  ? set_p1
                      : hit_acc ? hit_updt_set_i
                      : '0;
    assign updt_way_o = vld_p1  ? sel_victim_way_i
                      : hit_acc ? hit_updt_way_i
                      : '0;

    // ---------------------------------------------------------- response FIFO
    // The slot was reserved in S0, so the push never overflows.
    assign fifo_push = vld_p1;
    assign fifo_pop  = rsp_valid_o && rsp_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_wr_q  <= 1'b0;
            fifo_rd_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (fifo_push) begin
                fifo_wr_q <= ~fifo_wr_q;
            end
            if (fifo_pop) begin
                fifo_rd_q <= ~fifo_rd_q;
            end
            fifo_cnt_q <= fifo_cnt_q + 2'(fifo_push) - 2'(fifo_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (fifo_push) begin
            fifo_id_q[fifo_wr_q]  <= id_p1;
            fifo_set_q[fifo_wr_q] <= set_p1;
            fifo_way_q[fifo_wr_q] <= sel_victim_way_i;
        end
    end

    // The head entry is held until it is popped, so the fields stay stable
    // under back-pressure. They are forced to zero while the FIFO is empty.
    assign rsp_valid_o = (fifo_cnt_q != 2'd0);
    assign rsp_id_o    = rsp_valid_o ? fifo_id_q[fifo_rd_q]  : '0;
    assign rsp_set_o   = rsp_valid_o ? fifo_set_q[fifo_rd_q] : '0;
    assign rsp_way_o   = rsp_valid_o ? fifo_way_q[fifo_rd_q] : '0;

endmodule

// File: tb/tb_hpdcache_victim_sel_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for hpdcache_victim_sel_ctrl.
//
// The bench acts as the cache environment. A PLRU victim selector with its
// policy RAM answers sel_victim_o combinationally. A reference model works at
// transaction level: the round-robin pointer, an S1 slot, a response count and
// a reference PLRU table. At every grant the model predicts the response and
// queues it. A monitor checks the queued responses against the DUT's response
// port.
// -----------------------------------------------------------------------------
module tb_hpdcache_victim_sel_ctrl;
    localparam int NREQ  = 2;
    localparam int SETS  = 64;
    localparam int WAYS  = 4;
    localparam int SET_W = 6;
    localparam int ID_W  = 1;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [SET_W-1:0] set;
        logic [WAYS-1:0]  way;
    } rsp_t;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic [NREQ-1:0]       req_valid_i;
    logic [NREQ*SET_W-1:0] req_set_i;
    logic [NREQ-1:0]       req_ready_o;
    logic                  dir_rd_o;
    logic [SET_W-1:0]      dir_set_o;
    logic [WAYS-1:0]       dir_valid_i, dir_wback_i, dir_dirty_i, dir_fetch_i;
    logic                  sel_victim_o;
    logic [SET_W-1:0]      sel_victim_set_o;
    logic [WAYS-1:0]       sel_dir_valid_o, sel_dir_wback_o, sel_dir_dirty_o, sel_dir_fetch_o;
    logic [WAYS-1:0]       sel_victim_way_i;
    logic                  updt_o;
    logic [SET_W-1:0]      updt_set_o;
    logic [WAYS-1:0]       updt_way_o;
    logic                  hit_updt_valid_i;
    logic [SET_W-1:0]      hit_updt_set_i;
    logic [WAYS-1:0]       hit_updt_way_i;
    logic                  hit_updt_ready_o;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [ID_W-1:0]       rsp_id_o;
    logic [SET_W-1:0]      rsp_set_o;
    logic [WAYS-1:0]       rsp_way_o;

    hpdcache_victim_sel_ctrl #(.NREQ(NREQ), .SETS(SETS), .WAYS(WAYS)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_set_i(req_set_i), .req_ready_o(req_ready_o),
        .dir_rd_o(dir_rd_o), .dir_set_o(dir_set_o),
        .dir_valid_i(dir_valid_i), .dir_wback_i(dir_wback_i),
        .dir_dirty_i(dir_dirty_i), .dir_fetch_i(dir_fetch_i),
        .sel_victim_o(sel_victim_o), .sel_victim_set_o(sel_victim_set_o),
        .sel_dir_valid_o(sel_dir_valid_o), .sel_dir_wback_o(sel_dir_wback_o),
        .sel_dir_dirty_o(sel_dir_dirty_o), .sel_dir_fetch_o(sel_dir_fetch_o),
        .sel_victim_way_i(sel_victim_way_i),
        .updt_o(updt_o), .updt_set_o(updt_set_o), .updt_way_o(updt_way_o),
        .hit_updt_valid_i(hit_updt_valid_i), .hit_updt_set_i(hit_updt_set_i),
        .hit_updt_way_i(hit_updt_way_i), .hit_updt_ready_o(hit_updt_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_id_o(rsp_id_o), .rsp_set_o(rsp_set_o), .rsp_way_o(rsp_way_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- 4-way tree PLRU: bit0 root (1 = right pair), bit1 pair01, bit2 pair23
    function automatic logic [2:0] plru_touch(logic [2:0] t, logic [3:0] way);
        logic [2:0] r;
        r = t;
        if (way[0])      begin r[0] = 1'b1; r[1] = 1'b1; end
        else if (way[1]) begin r[0] = 1'b1; r[1] = 1'b0; end
        else if (way[2]) begin r[0] = 1'b0; r[2] = 1'b1; end
        else if (way[3]) begin r[0] = 1'b0; r[2] = 1'b0; end
        return r;
    endfunction

    function automatic logic [3:0] pick_way(logic [3:0] valid, logic [2:0] t);
        for (int i = 0; i < 4; i++) begin
            if (!valid[i]) return 4'(1 << i);
        end
        if (!t[0]) return t[1] ? 4'b0010 : 4'b0001;
        return t[2] ? 4'b1000 : 4'b0100;
    endfunction

    // Environment: selector plus policy RAM, driven by the DUT's ports
    logic [2:0] env_tree [SETS] = '{default: 3'b000};
    always_comb sel_victim_way_i = pick_way(sel_dir_valid_o, env_tree[sel_victim_set_o]);
    always @(posedge clk_i) begin
        if (updt_o) env_tree[updt_set_o] <= plru_touch(env_tree[updt_set_o], updt_way_o);
    end

    // ---------------- reference model state
    logic [2:0]       ref_tree [SETS] = '{default: 3'b000};
    int               m_ptr;
    logic             m_s1_v;
    int               m_s1_id;
    logic [SET_W-1:0] m_s1_set;
    int               m_count;
    int               c_g;
    logic [SET_W-1:0] c_gset;
    logic             c_push, c_pop, c_upd, c_hit_acc;
    logic [SET_W-1:0] c_uset;
    logic [WAYS-1:0]  c_uway;

    rsp_t       exp_q[$];
    logic [3:0] popped[$];
    rsp_t       mon_e;
    int         n_cmp  = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_s1_v = 1'b0; m_s1_id = 0; m_s1_set = '0; m_count = 0;
        c_g = -1; c_gset = '0; c_push = 0; c_pop = 0; c_upd = 0; c_hit_acc = 0;
        c_uset = '0; c_uway = '0;
        exp_q.delete();
    endtask

    // Predict this cycle from model state and the driven inputs, then compare at the negedge.
    task automatic eval_cycle();
        logic [WAYS-1:0] w;
        c_g = -1; c_gset = '0; c_push = 0; c_upd = 0; c_hit_acc = 0; c_uset = '0; c_uway = '0;
        if ((m_s1_v ? 1 : 0) + m_count < 2) begin
            for (int k = 0; k < NREQ; k++) begin
                int i = (m_ptr + k) % NREQ;
                if (c_g < 0 && req_valid_i[i]) c_g = i;
            end
        end
        if (c_g >= 0) c_gset = req_set_i[c_g*SET_W +: SET_W];
        if (m_s1_v) begin
            w = pick_way(dir_valid_i, ref_tree[m_s1_set]);
            exp_q.push_back('{id: ID_W'(m_s1_id), set: m_s1_set, way: w});
            c_push = 1; c_upd = 1; c_uset = m_s1_set; c_uway = w;
        end else if (hit_updt_valid_i) begin
            c_upd = 1; c_hit_acc = 1; c_uset = hit_updt_set_i; c_uway = hit_updt_way_i;
        end
        c_pop = (m_count != 0) && rsp_ready_i;

        @(negedge clk_i);
        chk("req_ready", 32'(req_ready_o), (c_g >= 0) ? 32'(1 << c_g) : 32'd0);
        chk("dir_rd", 32'(dir_rd_o), 32'(c_g >= 0));
        if (c_g >= 0) chk("dir_set", 32'(dir_set_o), 32'(c_gset));
        chk("sel_victim", 32'(sel_victim_o), 32'(m_s1_v));
        if (m_s1_v) begin
            chk("sel_set", 32'(sel_victim_set_o), 32'(m_s1_set));
            chk("sel_dir_valid", 32'(sel_dir_valid_o), 32'(dir_valid_i));
            chk("sel_dir_wback", 32'(sel_dir_wback_o), 32'(dir_wback_i));
        end
        chk("updt", 32'(updt_o), 32'(c_upd));
        if (c_upd) begin
            chk("updt_set", 32'(updt_set_o), 32'(c_uset));
            chk("updt_way", 32'(updt_way_o), 32'(c_uway));
        end
        chk("hit_ready", 32'(hit_updt_ready_o), 32'(!m_s1_v));
        chk("rsp_valid", 32'(rsp_valid_o), 32'(m_count != 0));
    endtask

    task automatic commit();
        if (c_g >= 0) begin
            m_ptr = (c_g + 1) % NREQ;
            m_s1_v = 1'b1; m_s1_id = c_g; m_s1_set = c_gset;
        end else begin
            m_s1_v = 1'b0;
        end
        m_count = m_count + (c_push ? 1 : 0) - (c_pop ? 1 : 0);
        if (c_upd) ref_tree[c_uset] = plru_touch(ref_tree[c_uset], c_uway);
        if (c_hit_acc) hit_updt_valid_i = 1'b0;
    endtask

    task automatic tick();
        logic r;
        @(posedge clk_i);
        r = rst_ni;
        #1;
        if (r) commit();
    endtask

    task automatic run();
        eval_cycle();
        tick();
    endtask

    task automatic drive_dir(input bit all_valid);
        dir_valid_i = (all_valid || $urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
        dir_wback_i = 4'($urandom);
        dir_dirty_i = 4'($urandom);
        dir_fetch_i = 4'($urandom);
    endtask

    task automatic idle(input int n);
        req_valid_i = '0;
        rsp_ready_i = 1'b1;
        for (int k = 0; k < n; k++) begin
            drive_dir(1);
            run();
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready_o), 0);
        chk({tag, "_dir_rd"}, 32'(dir_rd_o), 0);
        chk({tag, "_dir_set"}, 32'(dir_set_o), 0);
        chk({tag, "_sel_victim"}, 32'(sel_victim_o), 0);
        chk({tag, "_sel_set"}, 32'(sel_victim_set_o), 0);
        chk({tag, "_sel_dir"}, 32'({sel_dir_valid_o, sel_dir_wback_o, sel_dir_dirty_o, sel_dir_fetch_o}), 0);
        chk({tag, "_updt"}, 32'({updt_o, updt_set_o, updt_way_o}), 0);
        chk({tag, "_hit_ready"}, 32'(hit_updt_ready_o), 0);
        chk({tag, "_rsp"}, 32'({rsp_valid_o, rsp_id_o, rsp_set_o, rsp_way_o}), 0);
    endtask

    // Monitor: the head must match the oldest expected response; pop on handshake.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && rsp_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rsp_unexpected: got id=%0h set=%0h way=%0h, expected no response",
                         rsp_id_o, rsp_set_o, rsp_way_o);
            end else begin
                mon_e = exp_q[0];
                chk("rsp_id", 32'(rsp_id_o), 32'(mon_e.id));
                chk("rsp_set", 32'(rsp_set_o), 32'(mon_e.set));
                chk("rsp_way", 32'(rsp_way_o), 32'(mon_e.way));
                if (rsp_ready_i) begin
                    void'(exp_q.pop_front());
                    popped.push_back(rsp_way_o);
                end
            end
        end
    end

    initial begin
        // Reset state, with requests and a hit pending so gating is exercised
        rst_ni = 1'b0;
        req_valid_i = 2'b11; req_set_i = '1; rsp_ready_i = 1'b1;
        hit_updt_valid_i = 1'b1; hit_updt_set_i = 6'd1; hit_updt_way_i = 4'b0001;
        drive_dir(0);
        model_reset();
        @(negedge clk_i); #1;
        check_zero("reset");
        @(posedge clk_i); #1;
        rst_ni = 1'b1; hit_updt_valid_i = 1'b0; req_valid_i = '0;

        // Single request: req0 set 5
        rsp_ready_i = 1'b1;
        req_valid_i = 2'b01; req_set_i = {6'd0, 6'd5}; drive_dir(1);
        run();
        idle(4);

        // Both requesters valid continuously, ready high
        for (int k = 0; k < 12; k++) begin
            req_valid_i = 2'b11; req_set_i = 12'($urandom); rsp_ready_i = 1'b1; drive_dir(0);
            run();
        end
        idle(4);

        // Back-pressure: responses blocked, then one pop, then blocked again
        for (int k = 0; k < 6; k++) begin
            req_valid_i = 2'b11; req_set_i = 12'($urandom); rsp_ready_i = 1'b0; drive_dir(0);
            run();
        end
        rsp_ready_i = 1'b1; drive_dir(0); run();
        for (int k = 0; k < 3; k++) begin
            rsp_ready_i = 1'b0; drive_dir(0); run();
        end
        idle(5);

        // Hit update arriving while S1 holds set 3
        req_valid_i = 2'b01; req_set_i = {6'd0, 6'd3}; drive_dir(1);
        run();
        req_valid_i = 2'b00;
        hit_updt_valid_i = 1'b1; hit_updt_set_i = 6'd9; hit_updt_way_i = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            drive_dir(1); run();
        end
        idle(4);

        // Two back-to-back requests to set 7, all ways valid: distinct victims
        popped.delete();
        rsp_ready_i = 1'b1;
        req_valid_i = 2'b01; req_set_i = {6'd0, 6'd7}; drive_dir(1); run();
        req_valid_i = 2'b10; req_set_i = {6'd7, 6'd0}; drive_dir(1); run();
        idle(5);
        chk("same_set_count", popped.size(), 2);
        if (popped.size() == 2) begin
            chk("same_set_distinct", 32'(popped[0] != popped[1]), 1);
            chk("same_set_onehot", 32'($onehot(popped[0]) && $onehot(popped[1])), 1);
        end

        // Randomized traffic with small set range to provoke same-set hazards
        for (int k = 0; k < 1500; k++) begin
            req_valid_i = 2'($urandom_range(0, 3));
            req_set_i = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
            rsp_ready_i = ($urandom_range(0, 3) != 0);
            if (!hit_updt_valid_i && $urandom_range(0, 5) == 0) begin
                hit_updt_valid_i = 1'b1;
                hit_updt_set_i = 6'($urandom_range(0, 7));
                hit_updt_way_i = 4'(1 << $urandom_range(0, 3));
            end
            drive_dir(0);
            run();
        end
        hit_updt_valid_i = 1'b0;
        idle(6);

        // Reset while S1 is occupied and the FIFO holds one entry
        rsp_ready_i = 1'b0;
        req_valid_i = 2'b10; req_set_i = {6'd12, 6'd0}; drive_dir(1); run();
        req_valid_i = 2'b01; req_set_i = {6'd0, 6'd13}; drive_dir(1); run();
        req_valid_i = 2'b11; hit_updt_valid_i = 1'b1; drive_dir(1);
        #1 rst_ni = 1'b0;
        #1 check_zero("mid_rst");
        model_reset();
        @(posedge clk_i); #1;
        rst_ni = 1'b1; hit_updt_valid_i = 1'b0; rsp_ready_i = 1'b1;
        req_valid_i = 2'b11; req_set_i = {6'd21, 6'd20}; drive_dir(1);
        run();
        for (int k = 0; k < 20; k++) begin
            req_valid_i = 2'($urandom_range(0, 3)); req_set_i = 12'($urandom);
            rsp_ready_i = ($urandom_range(0, 1) != 0); drive_dir(0);
            run();
        end
        idle(6);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
